priv_ext_csr_master: RTL and testbench

Initiator side of the privilege-extension CSR interface. It accepts one CSR access at a time from the core CSR unit and runs it on the extension bus as a read phase followed by an optional write phase. Extension responders such as the PMA/PMP register files answer on that bus. The block returns the old CSR value, or an illegal-access flag when the access fails. It sits between the priv CSR decode and all extension responders, which share the bus through an OR-reduced ack/value_out return path.

---
 rtl/priv_ext_csr_master.sv | 197 +++++++++++++++++++
 tb/tb_priv_ext_csr_master.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/priv_ext_csr_master.sv
// priv_ext_csr_master
// Initiator side of the privilege-extension CSR bus. Takes one CSR access at a
// time from the core CSR unit and runs it as a read phase followed by an
// optional write phase. Returns the old CSR value or an illegal-access flag.
//
// Ports:
//   CLK, nRST           clock, asynchronous active-low reset
//   req_valid/req_ready request handshake (ready only in IDLE)
//   req_addr/op/wdata   CSR address, op (00 RW, 01 RS, 10 RC, 11 RO), operand
//   resp_valid          one-cycle completion pulse
//   resp_rdata          old CSR value, 0 when illegal
//   resp_illegal        access failed, qualified by resp_valid
//   csr_addr            address to extensions
//   csr_active          write strobe to extensions
//   value_in            write data to extensions
//   ack/value_out       OR-reduced claim and read data from the responders
//   invalid_csr         claiming responder rejects the access
module priv_ext_csr_master #(
    parameter int unsigned ACK_TIMEOUT = 15,
    parameter int unsigned DATA_W      = 32
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [11:0]       req_addr,
    input  logic [1:0]        req_op,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_illegal,
    output logic [11:0]       csr_addr,
    output logic              csr_active,
    output logic [DATA_W-1:0] value_in,
    input  logic              ack,
    input  logic [DATA_W-1:0] value_out,
    input  logic              invalid_csr
);

    localparam int unsigned CntW = $clog2(ACK_TIMEOUT + 1);

    localparam logic [1:0] OpRw = 2'b00;
    localparam logic [1:0] OpRs = 2'b01;
    localparam logic [1:0] OpRc = 2'b10;
    localparam logic [1:0] OpRo = 2'b11;

    typedef enum logic [1:0] {StIdle, StRead, StWrite, StResp} state_e;

    state_e            state_q, state_d;
    logic [1:0]        op_q, op_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] old_q, old_d;
    logic [11:0]       addr_q, addr_d;
    logic              active_q, active_d;
    logic [DATA_W-1:0] vin_q, vin_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              rvalid_q, rvalid_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              rill_q, rill_d;

    logic [DATA_W-1:0] new_val;
    logic              skip_wr;
    logic              timeout;
    logic [CntW-1:0]   cnt_inc;

    always_comb begin
        unique case (op_q)
            OpRw:    new_val = wdata_q;
            OpRs:    new_val = value_out | wdata_q;
            OpRc:    new_val = value_out & ~wdata_q;
            default: new_val = value_out;
        endcase
        // Set/clear with a zero operand cannot change the CSR, so no write.
        skip_wr = (op_q == OpRo) || ((op_q != OpRw) && (wdata_q == '0));
        timeout = (cnt_q == CntW'(ACK_TIMEOUT - 1));
        cnt_inc = (cnt_q == CntW'(ACK_TIMEOUT)) ? cnt_q : cnt_q + 1'b1;
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        wdata_d  = wdata_q;
        old_d    = old_q;
        addr_d   = addr_q;
        active_d = active_q;
        vin_d    = vin_q;
        cnt_d    = cnt_q;
        // Response fields are only non-zero during the RESP cycle.
        rvalid_d = 1'b0;
        rdata_d  = '0;
        rill_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    op_d    = req_op;
                    wdata_d = req_wdata;
                    if ((req_addr[11:10] == 2'b11) && (req_op != OpRo)) begin
                        // Read-only CSR space: reject without touching the bus.
                        state_d  = StResp;
                        rvalid_d = 1'b1;
                        rill_d   = 1'b1;
                    end else begin
                        addr_d   = req_addr;
                        active_d = 1'b0;
                        cnt_d    = '0;
                        state_d  = StRead;
                    end
                end
            end
            StRead: begin
                // Ack is checked before timeout so a last-cycle ack is honoured.
                if (ack) begin
                    if (invalid_csr) begin
                        state_d  = StResp;
                        rvalid_d = 1'b1;
                        rill_d   = 1'b1;
                    end else begin
                        old_d = value_out;
                        if (skip_wr) begin
                            state_d  = StResp;
                            rvalid_d = 1'b1;
                            rdata_d  = value_out;
                        end else begin
                            vin_d    = new_val;
                            active_d = 1'b1;
                            cnt_d    = '0;
                            state_d  = StWrite;
                        end
                    end
                end else if (timeout) begin
                    state_d  = StResp;
                    rvalid_d = 1'b1;
                    rill_d   = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            StWrite: begin
                if (ack || timeout) begin
                    active_d = 1'b0;
                    state_d  = StResp;
                    rvalid_d = 1'b1;
                    if (ack && !invalid_csr) begin
                        rdata_d = old_q;
                    end else begin
                        rill_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            StResp: begin
                active_d = 1'b0;
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q  <= StIdle;
            op_q     <= OpRw;
            wdata_q  <= '0;
            old_q    <= '0;
            addr_q   <= '0;
            active_q <= 1'b0;
            vin_q    <= '0;
            cnt_q    <= '0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rill_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            wdata_q  <= wdata_d;
            old_q    <= old_d;
            addr_q   <= addr_d;
            active_q <= active_d;
            vin_q    <= vin_d;
            cnt_q    <= cnt_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            rill_q   <= rill_d;
        end
    end

    assign req_ready    = (state_q == StIdle);
    assign resp_valid   = rvalid_q;
    assign resp_rdata   = rdata_q;
    assign resp_illegal = rill_q;
    assign csr_addr     = addr_q;
    assign csr_active   = active_q;
    assign value_in     = vin_q;

endmodule

// File: tb/tb_priv_ext_csr_master.sv
// tb_priv_ext_csr_master
// Directed bench for priv_ext_csr_master. A single modelled responder claims
// one address, returns a fixed value and can reject reads/writes or delay its
// write ack. Response timing is reported as the cycle number of the resp_valid
// cycle, counting the accepting cycle as cycle 1.
module tb_priv_ext_csr_master;

    localparam int unsigned DATA_W = 32;

    logic              CLK;
    logic              nRST;
    logic              req_valid;
    logic              req_ready;
    logic [11:0]       req_addr;
    logic [1:0]        req_op;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_illegal;
    logic [11:0]       csr_addr;
    logic              csr_active;
    logic [DATA_W-1:0] value_in;
    logic              ack;
    logic [DATA_W-1:0] value_out;
    logic              invalid_csr;

    priv_ext_csr_master #(
        .ACK_TIMEOUT(15),
        .DATA_W     (DATA_W)
    ) dut (
        .CLK         (CLK),
        .nRST        (nRST),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .req_op      (req_op),
        .req_wdata   (req_wdata),
        .resp_valid  (resp_valid),
        .resp_rdata  (resp_rdata),
        .resp_illegal(resp_illegal),
        .csr_addr    (csr_addr),
        .csr_active  (csr_active),
        .value_in    (value_in),
        .ack         (ack),
        .value_out   (value_out),
        .invalid_csr (invalid_csr)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Responder model
    logic        claim_en;
    logic [11:0] claim_addr;
    logic [31:0] mem;
    logic        inv_rd;
    logic        inv_wr;
    int          wr_delay;
    int          wr_cnt;

    assign ack = claim_en && (csr_addr == claim_addr) && (!csr_active || (wr_cnt >= wr_delay));
    assign invalid_csr = ack && (csr_active ? inv_wr : inv_rd);
    assign value_out = mem;

    // Bus monitors (monotonic counters; the stimulus compares deltas)
    int          active_cycles;
    int          wr_commits;
    int          resp_pulses;
    int          vin_glitch;
    logic [31:0] last_wr;
    logic        prev_act;
    logic [31:0] prev_vin;

    initial begin
        wr_cnt        = 0;
        active_cycles = 0;
        wr_commits    = 0;
        resp_pulses   = 0;
        vin_glitch    = 0;
        last_wr       = '0;
        prev_act      = 1'b0;
        prev_vin      = '0;
    end

    always @(posedge CLK) begin
        wr_cnt   <= csr_active ? wr_cnt + 1 : 0;
        prev_act <= csr_active;
        prev_vin <= value_in;
        if (csr_active) active_cycles <= active_cycles + 1;
        if (csr_active && prev_act && (value_in != prev_vin)) vin_glitch <= vin_glitch + 1;
        if (csr_active && ack && !invalid_csr) begin
            wr_commits <= wr_commits + 1;
            last_wr    <= value_in;
        end
        if (resp_valid) resp_pulses <= resp_pulses + 1;
    end

    int n_vec;
    int n_err;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one request (called #1 after a rising edge with the DUT idle) and
    // wait for its response, bounded at 100 cycles.
    task automatic do_req(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] wd,
                          output int cyc, output logic [31:0] rd, output logic il);
        req_op    = op;
        req_addr  = addr;
        req_wdata = wd;
        req_valid = 1'b1;
        @(posedge CLK);
        #1;
        req_valid = 1'b0;
        cyc = 2;
        rd  = 'x;
        il  = 1'bx;
        while (!resp_valid && cyc < 100) begin
            @(posedge CLK);
            #1;
            cyc++;
        end
        if (resp_valid) begin
            rd = resp_rdata;
            il = resp_illegal;
        end else begin
            chk("resp_timeout", 32'd0, 32'd1);
        end
        @(posedge CLK);
        #1;
    endtask

    int          cyc;
    logic [31:0] rd;
    logic        il;
    int          a0, w0, p0, g0;

    initial begin
        n_vec     = 0;
        n_err     = 0;
        nRST      = 1'b0;
        req_valid = 1'b0;
        req_addr  = '0;
        req_op    = '0;
        req_wdata = '0;
        claim_en  = 1'b0;
        claim_addr = 12'h000;
        mem       = '0;
        inv_rd    = 1'b0;
        inv_wr    = 1'b0;
        wr_delay  = 0;

        repeat (3) @(posedge CLK);
        #1;
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_resp_illegal", {31'd0, resp_illegal}, 32'd0);
        chk("rst_csr_addr", {20'd0, csr_addr}, 32'd0);
        chk("rst_csr_active", {31'd0, csr_active}, 32'd0);
        chk("rst_value_in", value_in, 32'd0);
        nRST = 1'b1;
        @(posedge CLK);
        #1;

        // 1: RW, immediate acks: IDLE, READ, WRITE, RESP
        claim_en = 1'b1; claim_addr = 12'hBC3; mem = 32'h0000_2D2D;
        a0 = active_cycles; w0 = wr_commits;
        do_req(2'b00, 12'hBC3, 32'h1234_5678, cyc, rd, il);
        chk("rw_cyc", cyc, 32'd4);
        chk("rw_rdata", rd, 32'h0000_2D2D);
        chk("rw_illegal", {31'd0, il}, 32'd0);
        chk("rw_commits", wr_commits - w0, 32'd1);
        chk("rw_value_in", last_wr, 32'h1234_5678);
        chk("rw_active_cyc", active_cycles - a0, 32'd1);

        // 2: RS with zero operand skips the write; RC and RS compute new value
        claim_addr = 12'hBC0; mem = 32'hA5A5_A5A5;
        a0 = active_cycles;
        do_req(2'b01, 12'hBC0, 32'h0, cyc, rd, il);
        chk("rs0_cyc", cyc, 32'd3);
        chk("rs0_rdata", rd, 32'hA5A5_A5A5);
        chk("rs0_no_write", active_cycles - a0, 32'd0);
        do_req(2'b10, 12'hBC0, 32'h0000_00FF, cyc, rd, il);
        chk("rc_cyc", cyc, 32'd4);
        chk("rc_rdata", rd, 32'hA5A5_A5A5);
        chk("rc_value_in", last_wr, 32'hA5A5_A500);
        do_req(2'b01, 12'hBC0, 32'h0F00_0000, cyc, rd, il);
        chk("rs_value_in", last_wr, 32'hAFA5_A5A5);

        // 3: no responder: 15 READ cycles (cycles 2..16), RESP in cycle 17
        a0 = active_cycles;
        do_req(2'b00, 12'h7C0, 32'h1111_1111, cyc, rd, il);
        chk("to_cyc", cyc, 32'd17);
        chk("to_illegal", {31'd0, il}, 32'd1);
        chk("to_rdata", rd, 32'd0);
        chk("to_no_write", active_cycles - a0, 32'd0);

        // 4: read-only space
        do_req(2'b00, 12'hCC1, 32'h2222_2222, cyc, rd, il);
        chk("ro_space_cyc", cyc, 32'd2);
        chk("ro_space_illegal", {31'd0, il}, 32'd1);
        chk("ro_space_rdata", rd, 32'd0);
        chk("ro_space_no_bus", {20'd0, csr_addr}, 32'h7C0);
        claim_addr = 12'hCC1; mem = 32'hDEAD_BEEF;
        do_req(2'b11, 12'hCC1, 32'h0, cyc, rd, il);
        chk("ro_cyc", cyc, 32'd3);
        chk("ro_rdata", rd, 32'hDEAD_BEEF);
        chk("ro_illegal", {31'd0, il}, 32'd0);

        // 5a: read rejected
        claim_addr = 12'hBC3; mem = 32'h0000_2D2D; inv_rd = 1'b1;
        a0 = active_cycles;
        do_req(2'b00, 12'hBC3, 32'h3333_3333, cyc, rd, il);
        chk("rdinv_illegal", {31'd0, il}, 32'd1);
        chk("rdinv_rdata", rd, 32'd0);
        chk("rdinv_no_write", active_cycles - a0, 32'd0);

        // 5b: write ack delayed 5 cycles: WRITE spans cycles 3..8
        inv_rd = 1'b0; wr_delay = 5;
        a0 = active_cycles; g0 = vin_glitch;
        do_req(2'b00, 12'hBC3, 32'h0BAD_F00D, cyc, rd, il);
        chk("wrdly_cyc", cyc, 32'd9);
        chk("wrdly_active_cyc", active_cycles - a0, 32'd6);
        chk("wrdly_vin_stable", vin_glitch - g0, 32'd0);
        chk("wrdly_value_in", last_wr, 32'h0BAD_F00D);
        chk("wrdly_rdata", rd, 32'h0000_2D2D);
        chk("wrdly_illegal", {31'd0, il}, 32'd0);

        // 5c: write rejected discards old value
        wr_delay = 0; inv_wr = 1'b1; w0 = wr_commits;
        do_req(2'b00, 12'hBC3, 32'h4444_4444, cyc, rd, il);
        chk("wrinv_illegal", {31'd0, il}, 32'd1);
        chk("wrinv_rdata", rd, 32'd0);
        chk("wrinv_commits", wr_commits - w0, 32'd0);
        inv_wr = 1'b0;

        // 6: reset while in WRITE
        wr_delay = 5; w0 = wr_commits;
        req_op = 2'b00; req_addr = 12'hBC3; req_wdata = 32'h5555_5555; req_valid = 1'b1;
        @(posedge CLK);
        #1;
        req_valid = 1'b0;
        @(posedge CLK);
        #1;
        chk("rst_mid_active_before", {31'd0, csr_active}, 32'd1);
        p0 = resp_pulses;
        nRST = 1'b0;
        #1;
        chk("rst_mid_active_drop", {31'd0, csr_active}, 32'd0);
        @(posedge CLK);
        #1;
        nRST = 1'b1;
        chk("rst_mid_ready", {31'd0, req_ready}, 32'd1);
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_mid_no_resp", resp_pulses - p0, 32'd0);
        chk("rst_mid_no_commit", wr_commits - w0, 32'd0);
        wr_delay = 0;
        do_req(2'b11, 12'hBC3, 32'h0, cyc, rd, il);
        chk("post_rst_cyc", cyc, 32'd3);
        chk("post_rst_rdata", rd, 32'h0000_2D2D);
        chk("post_rst_illegal", {31'd0, il}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
